// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies use a 32-step shift-add on operand magnitudes, divides a 32-step
// restoring shift-subtract. Results are sign-corrected at the last step and
// presented as a one-cycle register-file write-back (done / wb_addr / wb_data).
// Divide-by-zero and signed overflow skip the iterative phase entirely.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Two's-complement magnitude of a value whose sign bit is to be honoured.
    function automatic logic [31:0] magnitude(input logic [31:0] val, input logic neg);
        magnitude = neg ? (32'd0 - val) : val;
    endfunction

    state_t      state_r;
    state_t      next_state_s;

    logic [2:0]  op_r;
    logic [4:0]  rd_r;
    logic [4:0]  cnt_r;
    logic        neg_res_r;      // negate product / quotient
    logic        neg_rem_r;      // negate remainder
    logic [63:0] acc_r;          // multiply accumulator
    logic [63:0] mcand_r;        // shifted multiplicand
    logic [31:0] mplr_r;         // multiplier, consumed LSB first
    logic [31:0] rem_r;          // partial remainder
    logic [31:0] quo_r;          // dividend shifting out / quotient shifting in
    logic [31:0] dvsr_r;         // divisor magnitude

    // Operand decode on the request inputs
    logic        a_signed_s;
    logic        b_signed_s;
    logic        sign_a_s;
    logic        sign_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        special_s;
    logic [31:0] special_res_s;
    logic        accept_s;

    // Iteration datapath
    logic        last_step_s;
    logic [63:0] mul_sum_s;
    logic [63:0] prod_s;
    logic [32:0] rem_shift_s;
    logic [32:0] diff_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic [31:0] quot_res_s;
    logic [31:0] rem_res_s;
    logic [31:0] calc_res_s;

    assign accept_s    = (state_r == ST_IDLE) && start;
    assign last_step_s = (cnt_r == 5'd31);

    // Decode signedness, magnitudes and the no-iteration divide cases.
    always_comb begin
        a_signed_s    = 1'b0;
        b_signed_s    = 1'b0;
        special_s     = 1'b0;
        special_res_s = 32'd0;
        case (op)
            OP_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            OP_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            OP_DIV,
            OP_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            OP_MUL,
            OP_MULHU,
            OP_DIVU,
            OP_REMU:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
            default:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        sign_a_s = a_signed_s & rs1_data[31];
        sign_b_s = b_signed_s & rs2_data[31];
        mag_a_s  = magnitude(rs1_data, sign_a_s);
        mag_b_s  = magnitude(rs2_data, sign_b_s);

        if (op[2] && (rs2_data == 32'd0)) begin
            special_s     = 1'b1;
            special_res_s = op[1] ? rs1_data : 32'hFFFF_FFFF;
        end else if (op[2] && !op[0] && (rs1_data == 32'h8000_0000) &&
                     (rs2_data == 32'hFFFF_FFFF)) begin
            special_s     = 1'b1;
            special_res_s = op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_s     = 1'b0;
            special_res_s = 32'd0;
        end
    end

    // One multiply or divide step, plus the sign-corrected final result.
    always_comb begin
        mul_sum_s   = mplr_r[0] ? (acc_r + mcand_r) : acc_r;
        prod_s      = neg_res_r ? (64'd0 - mul_sum_s) : mul_sum_s;
        rem_shift_s = {rem_r, quo_r[31]};
        diff_s      = rem_shift_s - {1'b0, dvsr_r};
        rem_next_s  = diff_s[32] ? rem_shift_s[31:0] : diff_s[31:0];
        quo_next_s  = {quo_r[30:0], ~diff_s[32]};
        quot_res_s  = neg_res_r ? (32'd0 - quo_next_s) : quo_next_s;
        rem_res_s   = neg_rem_r ? (32'd0 - rem_next_s) : rem_next_s;
        case (op_r)
            OP_MUL:    calc_res_s = prod_s[31:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  calc_res_s = prod_s[63:32];
            OP_DIV,
            OP_DIVU:   calc_res_s = quot_res_s;
            OP_REM,
            OP_REMU:   calc_res_s = rem_res_s;
            default:   calc_res_s = 32'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = special_s ? ST_DONE : ST_CALC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_step_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Registered status and write-back outputs; result loads only on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 32'd0;
        end else begin
            busy <= (next_state_s != ST_IDLE);
            done <= (next_state_s == ST_DONE);
            if (accept_s && special_s) begin
                wb_addr <= rd_addr;
                wb_data <= special_res_s;
            end else if ((state_r == ST_CALC) && last_step_s) begin
                wb_addr <= rd_r;
                wb_data <= calc_res_s;
            end else begin
                wb_addr <= wb_addr;
                wb_data <= wb_data;
            end
        end
    end

    // Operand capture and per-cycle iteration of the shift-add / shift-subtract.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= 3'd0;
            rd_r      <= 5'd0;
            cnt_r     <= 5'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            acc_r     <= 64'd0;
            mcand_r   <= 64'd0;
            mplr_r    <= 32'd0;
            rem_r     <= 32'd0;
            quo_r     <= 32'd0;
            dvsr_r    <= 32'd0;
        end else if (accept_s) begin
            op_r      <= op;
            rd_r      <= rd_addr;
            cnt_r     <= 5'd0;
            neg_res_r <= sign_a_s ^ sign_b_s;
            neg_rem_r <= sign_a_s;
            acc_r     <= 64'd0;
            mcand_r   <= {32'd0, mag_a_s};
            mplr_r    <= mag_b_s;
            rem_r     <= 32'd0;
            quo_r     <= mag_a_s;
            dvsr_r    <= mag_b_s;
        end else if (state_r == ST_CALC) begin
            cnt_r <= cnt_r + 5'd1;
            if (op_r[2]) begin
                rem_r <= rem_next_s;
                quo_r <= quo_next_s;
            end else begin
                acc_r   <= mul_sum_s;
                mcand_r <= {mcand_r[62:0], 1'b0};
                mplr_r  <= {1'b0, mplr_r[31:1]};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops vs a
// plain-arithmetic reference model, and hand sequences for start-ignore and reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint p;
        logic [63:0] pu;
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (o)
            3'b000: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
            3'b001: begin p = longint'(sa) * longint'(sb); pu = p; return pu[63:32]; end
            3'b010: begin p = longint'(sa) * longint'({32'd0, b}); pu = p; return pu[63:32]; end
            3'b011: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (o[2] && b == 32'd0) return 1;
        if ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op; optionally pulse a different start request at cycle pulse_k.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int pulse_k,
                          output logic [31:0] res, output logic [4:0] adr,
                          output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        res = 32'd0;
        adr = 5'd0;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == pulse_k) begin
                op = 3'b000; rs1_data = 32'h0000_1234; rs2_data = 32'h0000_0055;
                rd_addr = 5'd9; start = 1'b1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                res = wb_data;
                adr = wb_addr;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("busy_clear",     {63'd0, busy}, 64'd0);
    endtask

    task automatic run_and_check(input string name, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp, input int exp_lat, input int pulse_k);
        logic [31:0] res;
        logic [4:0]  adr;
        int lat, bc;
        run_op(o, a, b, rd, pulse_k, res, adr, lat, bc);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_data"},    {32'd0, res}, {32'd0, exp});
        check({name, "_addr"},    {59'd0, adr}, {59'd0, rd});
        check({name, "_busycnt"}, 64'(bc), 64'(exp_lat));
        check({name, "_held"},    {32'd0, wb_data}, {32'd0, exp});
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        logic [4:0]  rr;
        int          rsel;
        bit          seen_done;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,          5'd7,  32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,          5'd8,  32'd2,         33};
        vecs[8]  = '{3'b100, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,          32'd0,          5'd11, 32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1};
        vecs[12] = '{3'b101, 32'd9,          32'd0,          5'd0,  32'hFFFF_FFFF, 1};
        vecs[13] = '{3'b111, 32'd9,          32'd0,          5'd31, 32'd9,         1};

        rst = 1'b1; start = 1'b0; op = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy",    {63'd0, busy},    64'd0);
        check("reset_done",    {63'd0, done},    64'd0);
        check("reset_wb_addr", {59'd0, wb_addr}, 64'd0);
        check("reset_wb_data", {32'd0, wb_data}, 64'd0);

        for (int i = 0; i < 14; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].rd, vecs[i].exp, vecs[i].lat, 0);
        end

        // start pulsed mid-CALC must be ignored.
        run_and_check("ignore_start", 3'b000, 32'd6, 32'd7, 5'd14, 32'd42, 33, 5);

        // Reset during step 10 aborts the op with no write-back.
        @(negedge clk);
        op = 3'b001; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0; rd_addr = 5'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",    {63'd0, busy},    64'd0);
        check("midrst_done",    {63'd0, done},    64'd0);
        check("midrst_wb_addr", {59'd0, wb_addr}, 64'd0);
        check("midrst_wb_data", {32'd0, wb_data}, 64'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("midrst_no_wb", {63'd0, seen_done}, 64'd0);
        run_and_check("post_rst_mul", 3'b000, 32'd3, 32'd4, 5'd20, 32'd12, 33, 0);

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rr = 5'($urandom_range(0, 31));
            rsel = $urandom_range(0, 5);
            case (rsel)
                0: ra = 32'd0;
                1: ra = 32'h8000_0000;
                2: ra = 32'hFFFF_FFFF;
                3: ra = 32'($urandom_range(0, 50));
                default: ra = $urandom;
            endcase
            rsel = $urandom_range(0, 5);
            case (rsel)
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 13));
                default: rb = $urandom;
            endcase
            run_and_check($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rr,
                          ref_result(ro, ra, rb), ref_latency(ro, ra, rb), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
